// File: rtl/four_bit_register_pkg.sv
// Shared defaults and data type for the four_bit_register storage element.
package four_bit_register_pkg;

    localparam int REG_WIDTH_DEFAULT = 4;
    localparam int REG_RESET_DEFAULT = 0;

    typedef logic [3:0] reg_data_t;

endpackage

// File: rtl/four_bit_register_dff_bit.sv
// Single-bit D flip-flop with synchronous active-high reset to a fixed value.
module dff_bit #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/four_bit_register.sv
// WIDTH-bit edge-triggered register built from dff_bit cells, synchronous reset.
// Optional simulation-only input X/Z check: define FOUR_BIT_REGISTER_XCHECK_EN.
module four_bit_register
    import four_bit_register_pkg::*;
#(
    parameter int                 WIDTH       = REG_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0]   RESET_VALUE = WIDTH'(REG_RESET_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [WIDTH-1:0] w_d;
    logic             w_reset;

`ifdef FOUR_BIT_REGISTER_XCHECK_EN
    // Unknown d_in holds the old value; unknown reset poisons the whole word.
    always_comb begin
        w_reset = (reset === 1'b1);
        w_d     = d_in;
        if ($isunknown(reset)) begin
            w_d = {WIDTH{1'bx}};
        end else if ($isunknown(d_in)) begin
            w_d = d_out;
        end
    end

    always_ff @(posedge clk) begin
        if ($isunknown(reset)) begin
            $error("%0t: four_bit_register reset is X/Z", $time);
        end else if (!reset && $isunknown(d_in)) begin
            $error("%0t: four_bit_register d_in has X/Z: %b", $time, d_in);
        end
    end
`else
    assign w_reset = reset;
    assign w_d     = d_in;
`endif

    for (genvar g_i = 0; g_i < WIDTH; g_i++) begin : g_bit
        dff_bit #(
            .RESET_VAL (RESET_VALUE[g_i])
        ) u_dff_bit (
            .clk   (clk),
            .reset (w_reset),
            .d     (w_d[g_i]),
            .q     (d_out[g_i])
        );
    end

endmodule

// File: tb/tb_four_bit_register.sv
// Self-checking bench for four_bit_register: directed test-plan cases plus random stream.
module tb_four_bit_register;
    import four_bit_register_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    reg_data_t d_in;
    reg_data_t d_out;

    int n_checks = 0;
    int n_errors = 0;

    four_bit_register dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .d_out (d_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input reg_data_t obs, input reg_data_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive mid-cycle, let one edge pass, compare against the register rule.
    task automatic step(input string tag, input logic r, input reg_data_t d);
        reg_data_t exp;
        @(negedge clk);
        reset = r;
        d_in  = d;
        @(posedge clk);
        #1;
        exp = r ? reg_data_t'(0) : d;
        check_val(tag, d_out, exp);
    endtask

    initial begin
        reg_data_t prev;
        logic      r_rand;
        reg_data_t d_rand;

        reset = 1'b1;
        d_in  = 4'b1100;

        step("reset_pulse", 1'b1, 4'b1100);

        for (int i = 0; i < 16; i++) begin
            step("sweep", 1'b0, reg_data_t'(i));
        end

        // Hold: toggling between edges must not disturb the output.
        prev = d_out;
        @(negedge clk);
        d_in = 4'b1010;
        #1 check_val("hold_before_edge_a", d_out, prev);
        d_in = 4'b0101;
        #1 check_val("hold_before_edge_b", d_out, prev);
        d_in = 4'b1010;
        @(posedge clk);
        #1 check_val("hold_after_edge", d_out, 4'b1010);

        step("prio_setup", 1'b0, 4'b1111);
        step("prio_reset", 1'b1, 4'b0110);
        step("prio_reset_held", 1'b1, 4'b0110);
        step("prio_reset_held2", 1'b1, 4'b1111);
        step("release", 1'b0, 4'b1001);

        step("glitch_setup", 1'b0, 4'b0011);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        #1 check_val("glitch_no_effect", d_out, 4'b0011);
        step("glitch_next_edge", 1'b0, 4'b0110);

        for (int i = 0; i < 300; i++) begin
            r_rand = ($urandom_range(0, 7) == 0);
            d_rand = reg_data_t'($urandom_range(0, 15));
            step(r_rand ? "rand_reset" : "rand_data", r_rand, d_rand);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
